// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and frame geometry for the instruction-memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHECK, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 4;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_STEP = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, memory write port and status of the loader
interface imem_loader_if;
  logic start;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic mem_write_enabled;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic cpu_hold;
  logic busy;
  logic done;
  logic err_checksum;
  logic err_overflow;
  modport master(output start, in_data, in_valid,
                 input in_ready, mem_write_enabled, mem_address, mem_data,
                 cpu_hold, busy, done, err_checksum, err_overflow);
  modport slave(input start, in_data, in_valid,
                output in_ready, mem_write_enabled, mem_address, mem_data,
                cpu_hold, busy, done, err_checksum, err_overflow);
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// imem_loader_byte_assembler: big-endian 4-byte word builder shared by header and data words
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_en,
  output logic [31:0] o_word_out,
  output logic        o_word_done
);
  logic [23:0] r_shift;
  logic [1:0]  r_count;
  // shift accepted bytes in MSB first; the counter wraps so words chain back to back
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_byte_en) begin
      r_shift <= {r_shift[15:0], i_byte_in};
      r_count <= r_count + 2'd1;
    end
  end
  // the completed word includes the byte being accepted so the top can register it on this edge
  assign o_word_out  = {r_shift, i_byte_in};
  assign o_word_done = i_byte_en && (r_count == 2'(WORD_BYTES - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a checksummed word frame and writes it into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input logic clock,
  input logic reset,
  imem_loader_if.slave bus
);
  state_t      r_state, w_next;
  logic [31:0] r_count_n, r_words, r_next_addr, r_addr, r_data, w_word;
  logic [7:0]  r_csum;
  logic        r_we, r_err_c, r_err_o, w_acc, w_go, w_asm_en, w_word_done, w_in_frame;
  assign w_in_frame = r_state inside {HDR, DATA, CHECK};
  assign w_acc      = bus.in_valid && w_in_frame;
  assign w_go       = bus.start && (r_state inside {IDLE, DONE, ERROR});
  assign w_asm_en   = w_acc && (r_state inside {HDR, DATA});
  imem_loader_byte_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_go),
    .i_byte_in  (bus.in_data),
    .i_byte_en  (w_asm_en),
    .o_word_out (w_word),
    .o_word_done(w_word_done)
  );
  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state: header decides overflow/empty/data, last data word goes to checksum compare
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: w_next = bus.start ? HDR : r_state;
      HDR:   if (w_word_done) w_next = (w_word > 32'(MAX_WORDS)) ? ERROR : (w_word == '0) ? CHECK : DATA;
      DATA:  if (w_word_done && (r_words + 32'd1 == r_count_n)) w_next = CHECK;
      CHECK: if (w_acc) w_next = (bus.in_data == r_csum) ? DONE : ERROR;
      default: w_next = IDLE;
    endcase
  end
  // outputs: status decoded from state, memory port and errors from registers
  always_comb begin
    bus.in_ready          = w_in_frame;
    bus.busy              = w_in_frame;
    bus.done              = (r_state == DONE);
    bus.cpu_hold          = (r_state != DONE);
    bus.mem_write_enabled = r_we;
    bus.mem_address       = r_addr;
    bus.mem_data          = r_data;
    bus.err_checksum      = r_err_c;
    bus.err_overflow      = r_err_o;
  end
  // datapath: word count, address, write strobe, running checksum and sticky errors
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count_n   <= '0;
      r_words     <= '0;
      r_next_addr <= BASE_ADDR;
      r_addr      <= BASE_ADDR;
      r_data      <= '0;
      r_csum      <= '0;
      r_we        <= 1'b0;
      r_err_c     <= 1'b0;
      r_err_o     <= 1'b0;
    end else begin
      r_we <= (r_state == DATA) && w_word_done;
      if (w_go) begin
        r_count_n   <= '0;
        r_words     <= '0;
        r_next_addr <= BASE_ADDR;
        r_csum      <= '0;
        r_err_c     <= 1'b0;
        r_err_o     <= 1'b0;
      end else begin
        if (w_asm_en) r_csum <= r_csum ^ bus.in_data;
        if (r_state == HDR && w_word_done) begin
          r_count_n <= w_word;
          if (w_word > 32'(MAX_WORDS)) r_err_o <= 1'b1;
        end
        if (r_state == DATA && w_word_done) begin
          r_words     <= r_words + 32'd1;
          r_addr      <= r_next_addr;
          r_next_addr <= r_next_addr + 32'(ADDR_STEP);
          r_data      <= w_word;
        end
        if (r_state == CHECK && w_acc && bus.in_data != r_csum) r_err_c <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with hand-computed writes and flags
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0]  fr[$];
  logic [31:0] wa[$], wd[$];
  int wc[$], lat[$];
  imem_loader_if bus();
  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut (.clock(clk), .reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // log every write strobe with its cycle stamp
  always @(negedge clk) begin
    if (bus.mem_write_enabled) begin
      wa.push_back(bus.mem_address);
      wd.push_back(bus.mem_data);
      wc.push_back(cyc);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); lat.delete();
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int tries = 0;
    bit ok = 1'b0;
    while (!ok && tries < 64) begin
      @(negedge clk);
      if (gap && $urandom_range(0, 1) == 1) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1;
        bus.in_data = b;
        ok = bus.in_ready;
      end
      tries++;
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  // sends fr[0..upto-1]; pulses start before byte pulse_at; stamps each 4th data byte
  task automatic send_frame(input bit gap, input int upto, input int pulse_at);
    int n = {fr[0], fr[1], fr[2], fr[3]};
    for (int i = 0; i < upto; i++) begin
      if (i == pulse_at) pulse_start();
      send_byte(fr[i], gap);
      if (i >= 4 && i < 4 + 4 * n && (i - 4) % 4 == 3) lat.push_back(cyc);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic build_main(input logic [7:0] cs);
    fr = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
           8'h01, 8'h23, 8'h45, 8'h67, cs};
  endtask
  task automatic check_main_writes(input string tag);
    chk({tag, "_nwr"}, wa.size(), 2);
    if (wa.size() > 0) begin chk({tag, "_a0"}, wa[0], 32'h0); chk({tag, "_d0"}, wd[0], 32'hDEADBEEF); end
    if (wa.size() > 1) begin chk({tag, "_a1"}, wa[1], 32'h4); chk({tag, "_d1"}, wd[1], 32'h01234567); end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_we", bus.mem_write_enabled, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_data", bus.mem_data, 0);
    chk("rst_flags", {bus.cpu_hold, bus.busy, bus.done, bus.err_checksum, bus.err_overflow}, 5'b10000);
    // 1: good frame; XOR of 00 00 00 02 DE AD BE EF 01 23 45 67 is 0x20
    clear_log();
    pulse_start();
    @(negedge clk);
    chk("t1_busy", {bus.busy, bus.in_ready, bus.cpu_hold}, 3'b111);
    build_main(8'h20);
    send_frame(1'b0, fr.size(), -1);
    check_main_writes("t1");
    chk("t1_flags", {bus.done, bus.cpu_hold, bus.in_ready, bus.busy, bus.err_checksum}, 5'b10000);
    chk("t1_hold_addr", bus.mem_address, 32'h4);
    chk("t1_hold_data", bus.mem_data, 32'h01234567);
    foreach (lat[i]) if (i < wc.size()) chk("t1_lat", wc[i], lat[i]);
    // 2: bad checksum
    clear_log();
    pulse_start();
    build_main(8'h00);
    send_frame(1'b0, fr.size(), -1);
    check_main_writes("t2");
    chk("t2_flags", {bus.err_checksum, bus.err_overflow, bus.cpu_hold, bus.done, bus.in_ready}, 5'b10100);
    // 3: header count 1025 overflows
    clear_log();
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h04, 8'h01};
    send_frame(1'b0, fr.size(), -1);
    chk("t3_nwr", wa.size(), 0);
    chk("t3_flags", {bus.err_overflow, bus.err_checksum, bus.in_ready, bus.cpu_hold, bus.done}, 5'b10010);
    // 4: empty program
    clear_log();
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, fr.size(), -1);
    chk("t4_nwr", wa.size(), 0);
    chk("t4_flags", {bus.done, bus.cpu_hold, bus.err_overflow, bus.err_checksum}, 4'b1000);
    // 5: random valid gaps
    clear_log();
    pulse_start();
    build_main(8'h20);
    send_frame(1'b1, fr.size(), -1);
    check_main_writes("t5");
    chk("t5_done", bus.done, 1);
    chk("t5_nlat", lat.size(), 2);
    foreach (lat[i]) if (i < wc.size()) chk("t5_lat", wc[i], lat[i]);
    // 6: reset after 6 data bytes, then a full frame with a stray start mid-frame
    pulse_start();
    build_main(8'h20);
    send_frame(1'b0, 10, -1);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_nwr_rst", wa.size(), 0);
    chk("t6_idle", {bus.in_ready, bus.busy, bus.cpu_hold, bus.done}, 4'b0010);
    chk("t6_rst_addr", bus.mem_address, 0);
    pulse_start();
    send_frame(1'b0, fr.size(), 6);
    check_main_writes("t6");
    chk("t6_done", {bus.done, bus.cpu_hold, bus.err_checksum}, 3'b100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
